// File: rtl/snoop_bus_pkg.sv
// snoop_bus_pkg
//   Shared definitions for the snooping bus / main-memory block:
//   message codes, bus field positions, FSM state encoding, the
//   message struct and a helper that builds a bus word.
package snoop_bus_pkg;

  // Field widths and positions of a 15-bit bus message
  localparam int TAG_W      = 3;
  localparam int CODE_W     = 3;
  localparam int DATA_W     = 8;
  localparam int MSG_W      = 15;

  localparam int TAG_HI     = 14;
  localparam int TAG_LO     = 12;
  localparam int MSG_HI     = 11;
  localparam int MSG_LO     = 9;
  localparam int VALID_BIT  = 8;
  localparam int DATA_HI    = 7;
  localparam int DATA_LO    = 0;

  // Message codes
  localparam logic [CODE_W-1:0] MSG_NONE       = 3'b000;  // none / read hit
  localparam logic [CODE_W-1:0] MSG_WRITE_MISS = 3'b001;
  localparam logic [CODE_W-1:0] MSG_READ_MISS  = 3'b010;
  localparam logic [CODE_W-1:0] MSG_INVALIDATE = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BCAST   = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } bus_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [CODE_W-1:0] msg;
    logic              valid;
    logic [DATA_W-1:0] data;
  } bus_msg_t;

  function automatic bus_msg_t make_msg(input logic [TAG_W-1:0]  tag,
                                        input logic [CODE_W-1:0] code,
                                        input logic              valid,
                                        input logic [DATA_W-1:0] data);
    bus_msg_t m;
    m.tag   = tag;
    m.msg   = code;
    m.valid = valid;
    m.data  = data;
    return m;
  endfunction

  // Only a read miss is served from memory; every other code runs the
  // same bus sequence without touching it.
  function automatic logic reads_memory(input logic [CODE_W-1:0] code);
    case (code)
      MSG_READ_MISS:                              return 1'b1;
      MSG_NONE, MSG_WRITE_MISS, MSG_INVALIDATE:   return 1'b0;
      default:                                    return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/snoop_wb_fifo.sv
// snoop_wb_fifo
//   Write-back queue: DEPTH entries of {tag, data}. Up to N_PUSH
//   entries may be pushed per cycle (ascending push index order), one
//   entry is popped per cycle. A pop in the same cycle frees a slot for
//   that cycle's pushes. Pushes that do not fit are dropped and set the
//   sticky overflow flag.
// Ports:
//   clock, reset              clock, asynchronous active-high reset
//   push_valid/tag/data       per-source push strobes and payloads
//   pop                       remove head entry (ignored when empty)
//   head_tag, head_data       current head entry
//   empty                     queue holds no entries
//   overflow                  sticky, an entry was dropped
module snoop_wb_fifo
  import snoop_bus_pkg::*;
#(
  parameter int N_PUSH = 3,
  parameter int DEPTH  = 4   // must be a power of two
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PUSH-1:0]        push_valid,
  input  logic [TAG_W*N_PUSH-1:0]  push_tag,
  input  logic [DATA_W*N_PUSH-1:0] push_data,
  input  logic                     pop,
  output logic [TAG_W-1:0]         head_tag,
  output logic [DATA_W-1:0]        head_data,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [TAG_W-1:0]  tag_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg;

  logic          full;
  logic          do_pop;
  logic          drop;
  int            free_slots;
  int            push_cnt;
  logic [N_PUSH-1:0] accept;
  logic [AW-1:0]     slot [N_PUSH];

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign head_tag  = tag_mem[rd_ptr_reg];
  assign head_data = data_mem[rd_ptr_reg];
  assign overflow  = overflow_reg;

  // Allocate consecutive slots to the accepted pushes, lowest index first.
  always_comb begin
    do_pop     = pop && !empty;
    free_slots = (full ? 0 : DEPTH - int'(count_reg)) + (do_pop ? 1 : 0);
    push_cnt   = 0;
    drop       = 1'b0;
    accept     = '0;
    for (int i = 0; i < N_PUSH; i++) begin
      slot[i] = '0;
      if (push_valid[i]) begin
        if (push_cnt < free_slots) begin
          accept[i] = 1'b1;
          slot[i]   = AW'(int'(wr_ptr_reg) + push_cnt);
          push_cnt  = push_cnt + 1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= AW'(int'(wr_ptr_reg) + push_cnt);
      rd_ptr_reg   <= rd_ptr_reg + AW'(do_pop);
      count_reg    <= CW'(int'(count_reg) + push_cnt - (do_pop ? 1 : 0));
      overflow_reg <= overflow_reg | drop;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clock) begin
    for (int i = 0; i < N_PUSH; i++) begin
      if (accept[i]) begin
        tag_mem[slot[i]]  <= push_tag[i*TAG_W +: TAG_W];
        data_mem[slot[i]] <= push_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/snoop_bus_memory.sv
// snoop_bus_memory
//   Shared bus and main memory of a snooping coherence system.
//   Round-robin arbitration among cache requests, one-cycle broadcast,
//   snoop-reply merge from the non-requesting caches, read-miss service
//   from an 8-word memory, and a write-back queue draining into memory.
// Ports:
//   clock, reset          clock, asynchronous active-high reset
//   req_valid, req_msg    per-cache bus requests {tag,msg,valid,data}
//   resp_msg              per-cache snoop replies, same format
//   wb_valid/data/tag     per-cache write-back strobes and payloads
//   bus_out               broadcast bus (BCAST and DONE cycles)
//   mem_data              memory word for a read miss (DONE cycle)
//   grant                 one-hot completion pulse to the winner
//   busy                  transaction in progress
//   wb_overflow           sticky, a write-back was lost
module snoop_bus_memory
  import snoop_bus_pkg::*;
#(
  parameter int N_CACHES  = 3,
  parameter int MEM_WORDS = 8,
  parameter int WB_DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_CACHES-1:0]        req_valid,
  input  logic [MSG_W*N_CACHES-1:0]  req_msg,
  input  logic [MSG_W*N_CACHES-1:0]  resp_msg,
  input  logic [N_CACHES-1:0]        wb_valid,
  input  logic [DATA_W*N_CACHES-1:0] wb_data,
  input  logic [TAG_W*N_CACHES-1:0]  wb_tag,
  output logic [MSG_W-1:0]           bus_out,
  output logic [DATA_W-1:0]          mem_data,
  output logic [N_CACHES-1:0]        grant,
  output logic                       busy,
  output logic                       wb_overflow
);

  localparam int IDX_W = $clog2(N_CACHES);

  // ---------------------------------------------------------------
  // Per-cache field extraction
  // ---------------------------------------------------------------
  logic [TAG_W-1:0]  req_tag   [N_CACHES];
  logic [CODE_W-1:0] req_code  [N_CACHES];
  logic [N_CACHES-1:0] resp_valid;
  logic [TAG_W-1:0]  resp_tag  [N_CACHES];
  logic [DATA_W-1:0] resp_data [N_CACHES];
  logic [N_CACHES-1:0] unused_req_bits;
  logic [N_CACHES-1:0] unused_resp_bits;

  for (genvar gi = 0; gi < N_CACHES; gi++) begin : g_fields
    assign req_tag[gi]   = req_msg[gi*MSG_W + TAG_HI : gi*MSG_W + TAG_LO];
    assign req_code[gi]  = req_msg[gi*MSG_W + MSG_HI : gi*MSG_W + MSG_LO];
    assign resp_valid[gi] = resp_msg[gi*MSG_W + VALID_BIT];
    assign resp_tag[gi]  = resp_msg[gi*MSG_W + TAG_HI : gi*MSG_W + TAG_LO];
    assign resp_data[gi] = resp_msg[gi*MSG_W + DATA_HI : gi*MSG_W + DATA_LO];
    // A request carries no payload and a reply's code is irrelevant here.
    assign unused_req_bits[gi]  = ^req_msg[gi*MSG_W + VALID_BIT : gi*MSG_W + DATA_LO];
    assign unused_resp_bits[gi] = ^resp_msg[gi*MSG_W + MSG_HI : gi*MSG_W + MSG_LO];
  end

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  bus_state_e        state_reg, state_next;
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [IDX_W-1:0]  winner_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [CODE_W-1:0] code_reg;
  bus_msg_t          bus_out_reg;
  logic [DATA_W-1:0] mem_data_reg;
  logic [N_CACHES-1:0] grant_reg;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic              wr_pend_reg;
  logic [TAG_W-1:0]  wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;

  logic              fifo_empty;
  logic [TAG_W-1:0]  fifo_head_tag;
  logic [DATA_W-1:0] fifo_head_data;
  logic              drain_busy;

  // ---------------------------------------------------------------
  // Write-back queue and memory write stage
  // ---------------------------------------------------------------
  snoop_wb_fifo #(
    .N_PUSH (N_CACHES),
    .DEPTH  (WB_DEPTH)
  ) u_wb_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_valid (wb_valid),
    .push_tag   (wb_tag),
    .push_data  (wb_data),
    .pop        (!fifo_empty),
    .head_tag   (fifo_head_tag),
    .head_data  (fifo_head_data),
    .empty      (fifo_empty),
    .overflow   (wb_overflow)
  );

  // The head is popped into a registered write stage and lands in memory
  // one cycle later, so memory is only current once both the queue and
  // the write stage are empty.
  assign drain_busy = !fifo_empty || wr_pend_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= '0;
      end
      wr_pend_reg <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_pend_reg <= !fifo_empty;
      wr_addr_reg <= fifo_head_tag;
      wr_data_reg <= fifo_head_data;
      if (wr_pend_reg) begin
        mem[wr_addr_reg] <= wr_data_reg;
      end
    end
  end

  // ---------------------------------------------------------------
  // Round-robin arbiter: first requester at or after rr_ptr
  // ---------------------------------------------------------------
  logic             arb_found;
  logic [IDX_W-1:0] arb_winner;
  int               arb_idx;

  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    arb_idx    = 0;
    for (int i = 0; i < N_CACHES; i++) begin
      arb_idx = (int'(rr_ptr_reg) + i) % N_CACHES;
      if (!arb_found && req_valid[arb_idx]) begin
        arb_found  = 1'b1;
        arb_winner = IDX_W'(arb_idx);
      end
    end
  end

  // ---------------------------------------------------------------
  // Snoop merge: lowest-index non-requester with a valid, matching reply
  // ---------------------------------------------------------------
  logic              snoop_hit;
  logic [DATA_W-1:0] snoop_data;

  always_comb begin
    snoop_hit  = 1'b0;
    snoop_data = '0;
    for (int i = 0; i < N_CACHES; i++) begin
      if (!snoop_hit && (IDX_W'(i) != winner_reg) &&
          resp_valid[i] && (resp_tag[i] == tag_reg)) begin
        snoop_hit  = 1'b1;
        snoop_data = resp_data[i];
      end
    end
  end

  // ---------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (arb_found) state_next = ST_BCAST;
      ST_BCAST:   state_next = ST_COLLECT;
      ST_COLLECT: if (!drain_busy) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Outputs are registered: each is loaded on the edge entering the
  // cycle in which it is valid, and cleared on the edge leaving it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      winner_reg   <= '0;
      tag_reg      <= '0;
      code_reg     <= '0;
      bus_out_reg  <= '0;
      mem_data_reg <= '0;
      grant_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (arb_found) begin
            winner_reg  <= arb_winner;
            tag_reg     <= req_tag[arb_winner];
            code_reg    <= req_code[arb_winner];
            bus_out_reg <= make_msg(req_tag[arb_winner], req_code[arb_winner],
                                    1'b0, '0);
          end
        end
        ST_BCAST: begin
          bus_out_reg <= '0;
        end
        ST_COLLECT: begin
          if (!drain_busy) begin
            bus_out_reg  <= make_msg(tag_reg, code_reg, snoop_hit,
                                     snoop_hit ? snoop_data : '0);
            mem_data_reg <= reads_memory(code_reg) ? mem[tag_reg] : '0;
            grant_reg    <= N_CACHES'(1) << winner_reg;
          end
        end
        ST_DONE: begin
          bus_out_reg  <= '0;
          mem_data_reg <= '0;
          grant_reg    <= '0;
          rr_ptr_reg   <= (winner_reg == IDX_W'(N_CACHES - 1)) ? '0
                                                               : winner_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus_out  = bus_out_reg;
  assign mem_data = mem_data_reg;
  assign grant    = grant_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_snoop_bus_memory.sv
// tb_snoop_bus_memory
//   Directed bench for snoop_bus_memory: read miss with and without a
//   sharer, write-back ordering, other message codes, round-robin,
//   write-back overflow and reset during COLLECT.
module tb_snoop_bus_memory;
  import snoop_bus_pkg::*;

  localparam int N = 3;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [15*N-1:0] req_msg;
  logic [15*N-1:0] resp_msg;
  logic [N-1:0]   wb_valid;
  logic [8*N-1:0] wb_data;
  logic [3*N-1:0] wb_tag;
  logic [14:0]    bus_out;
  logic [7:0]     mem_data;
  logic [N-1:0]   grant;
  logic           busy;
  logic           wb_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  snoop_bus_memory #(
    .N_CACHES  (N),
    .MEM_WORDS (8),
    .WB_DEPTH  (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_msg     (req_msg),
    .resp_msg    (resp_msg),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_tag      (wb_tag),
    .bus_out     (bus_out),
    .mem_data    (mem_data),
    .grant       (grant),
    .busy        (busy),
    .wb_overflow (wb_overflow)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", name, obs, exp);
  endtask

  task automatic set_req(input int who, input logic on, input logic [2:0] tag, input logic [2:0] code);
    req_valid[who] = on;
    req_msg[who*15 +: 15] = {tag, code, 1'b0, 8'h00};
  endtask

  task automatic set_wb(input int who, input logic on, input logic [2:0] tag, input logic [7:0] d);
    wb_valid[who] = on;
    wb_tag[who*3 +: 3] = tag;
    wb_data[who*8 +: 8] = d;
  endtask

  // Ticks until grant is seen; returns the number of ticks taken.
  task automatic wait_grant(output int cycles);
    cycles = 0;
    while (grant == '0 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic read_mem(input int who, input logic [2:0] tag, input logic [7:0] exp, input string name);
    int c;
    set_req(who, 1'b1, tag, MSG_READ_MISS);
    wait_grant(c);
    chk({name, "_lat"}, c, 3);
    chk(name, mem_data, exp);
    set_req(who, 1'b0, 3'd0, 3'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset     = 1'b1;
    req_valid = '0;
    req_msg   = '0;
    resp_msg  = '0;
    wb_valid  = '0;
    wb_data   = '0;
    wb_tag    = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst_bus", bus_out, 15'h0);
    chk("rst_mem", mem_data, 8'h00);
    chk("rst_grant", grant, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovf", wb_overflow, 1'b0);
    reset = 1'b0;
    tick();

    // 1: read miss, no sharer, cache 0, tag 5
    set_req(0, 1'b1, 3'b101, MSG_READ_MISS);
    tick();
    chk("rm_bc_busy", busy, 1'b1);
    chk("rm_bc_bus", bus_out, {3'b101, 3'b010, 1'b0, 8'h00});
    tick();
    chk("rm_col_grant", grant, 3'b000);
    chk("rm_col_busy", busy, 1'b1);
    tick();
    chk("rm_grant", grant, 3'b001);
    chk("rm_bus", bus_out, {3'b101, 3'b010, 1'b0, 8'h00});
    chk("rm_mem", mem_data, 8'h00);
    set_req(0, 1'b0, 3'd0, 3'd0);
    tick();
    chk("rm_idle_busy", busy, 1'b0);
    chk("rm_idle_grant", grant, 3'b000);

    // 2: write-back from cache 1 in the same cycle as cache 0's read miss
    set_req(0, 1'b1, 3'd3, MSG_READ_MISS);
    set_wb(1, 1'b1, 3'd3, 8'h3C);
    tick();
    set_wb(1, 1'b0, 3'd0, 8'h00);
    wait_grant(c);
    chk("wb_lat", c + 1, 4);
    chk("wb_grant", grant, 3'b001);
    chk("wb_mem", mem_data, 8'h3C);
    chk("wb_bus", bus_out, {3'd3, 3'b010, 1'b0, 8'h00});
    set_req(0, 1'b0, 3'd0, 3'd0);
    tick();

    // 3: read miss with sharer; requester's own reply and mismatching tag ignored
    resp_msg[0*15 +: 15] = {3'b110, 3'b010, 1'b1, 8'hFF};
    resp_msg[1*15 +: 15] = {3'b101, 3'b010, 1'b1, 8'h77};
    resp_msg[2*15 +: 15] = {3'b101, 3'b010, 1'b1, 8'hA5};
    set_req(1, 1'b1, 3'b101, MSG_READ_MISS);
    wait_grant(c);
    chk("sh_lat", c, 3);
    chk("sh_grant", grant, 3'b010);
    chk("sh_bus", bus_out, {3'b101, 3'b010, 1'b1, 8'hA5});
    chk("sh_mem", mem_data, 8'h00);
    set_req(1, 1'b0, 3'd0, 3'd0);
    resp_msg = '0;
    tick();

    // 4: write miss on tag 3 (memory holds 3C) does not read memory
    resp_msg[0*15 +: 15] = {3'd3, 3'b000, 1'b1, 8'h5A};
    set_req(2, 1'b1, 3'd3, MSG_WRITE_MISS);
    wait_grant(c);
    chk("wm_grant", grant, 3'b100);
    chk("wm_bus", bus_out, {3'd3, 3'b001, 1'b1, 8'h5A});
    chk("wm_mem", mem_data, 8'h00);
    set_req(2, 1'b0, 3'd0, 3'd0);
    resp_msg = '0;
    tick();

    // 5: invalidate, reply with valid=0 does not count as a hit
    resp_msg[1*15 +: 15] = {3'd3, 3'b000, 1'b0, 8'hEE};
    set_req(2, 1'b1, 3'd3, MSG_INVALIDATE);
    wait_grant(c);
    chk("inv_grant", grant, 3'b100);
    chk("inv_bus", bus_out, {3'd3, 3'b011, 1'b0, 8'h00});
    set_req(2, 1'b0, 3'd0, 3'd0);
    resp_msg = '0;
    tick();

    // 6: round-robin, all held; rr_ptr is 0 here
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'(i), MSG_NONE);
    for (int k = 0; k < 4; k++) begin
      wait_grant(c);
      chk("rr_lat", c, 3);
      chk("rr_grant", grant, 3'b001 << (k % 3));
      chk("rr_bus", bus_out, {3'(k % 3), 3'b000, 1'b0, 8'h00});
      tick();
    end
    req_valid = '0;
    tick();
    chk("rr_idle", busy, 1'b0);

    // 7: overflow: 3 + 3 write-backs, depth 4, one pop frees a slot
    set_wb(0, 1'b1, 3'd0, 8'h10);
    set_wb(1, 1'b1, 3'd1, 8'h11);
    set_wb(2, 1'b1, 3'd2, 8'h12);
    tick();
    chk("ovf_first", wb_overflow, 1'b0);
    set_wb(0, 1'b1, 3'd4, 8'h14);
    set_wb(1, 1'b1, 3'd5, 8'h15);
    set_wb(2, 1'b1, 3'd6, 8'h16);
    tick();
    wb_valid = '0;
    chk("ovf_set", wb_overflow, 1'b1);
    repeat (6) tick();
    chk("ovf_sticky", wb_overflow, 1'b1);
    read_mem(1, 3'd0, 8'h10, "ovf_m0");
    read_mem(2, 3'd1, 8'h11, "ovf_m1");
    read_mem(0, 3'd2, 8'h12, "ovf_m2");
    read_mem(1, 3'd4, 8'h14, "ovf_m4");
    read_mem(2, 3'd5, 8'h15, "ovf_m5");
    read_mem(0, 3'd6, 8'h00, "ovf_m6");
    chk("ovf_still", wb_overflow, 1'b1);

    // 8: reset during COLLECT with a write-back still queued
    set_wb(0, 1'b1, 3'd7, 8'h99);
    tick();
    wb_valid = '0;
    repeat (3) tick();
    set_req(0, 1'b1, 3'd7, MSG_READ_MISS);
    tick();
    set_wb(1, 1'b1, 3'd6, 8'h66);
    tick();
    wb_valid = '0;
    chk("rc_busy", busy, 1'b1);
    chk("rc_grant", grant, 3'b000);
    reset = 1'b1;
    #1;
    chk("rc_bus0", bus_out, 15'h0);
    chk("rc_mem0", mem_data, 8'h00);
    chk("rc_grant0", grant, 3'b000);
    chk("rc_busy0", busy, 1'b0);
    chk("rc_ovf0", wb_overflow, 1'b0);
    set_req(0, 1'b0, 3'd0, 3'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rc_nogrant", grant, 3'b000);
      chk("rc_idle", busy, 1'b0);
    end
    read_mem(0, 3'd7, 8'h00, "rc_m7");
    read_mem(1, 3'd6, 8'h00, "rc_m6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
